// File: rtl/exec_muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide execute unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a final sign-fix cycle.
module exec_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_orig_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_signed_op;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed_op = ~op[0];
  assign w_abs_a = (w_signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign w_abs_b = (w_signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // Multiply: {hi,lo} accumulator, multiplier in the low half shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend/quotient bits in the low half.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quot_fix = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_b_zero  <= 1'b0;
      r_m       <= '0;
      r_orig_a  <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div  <= op[1];
            r_neg_res <= w_signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            r_neg_rem <= w_signed_op && operand_a[WIDTH-1];
            r_b_zero  <= (operand_b == '0);
            r_orig_a  <= operand_a;
            r_m       <= op[1] ? w_abs_b : w_abs_a;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            r_dbz     <= 1'b0;
            r_cnt     <= CNT_W'(WIDTH);
            r_state   <= CALC;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end else if (r_b_zero) begin
              r_hi  <= r_orig_a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quot_fix;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Scoreboard bench for exec_muldiv_unit at WIDTH=32 and WIDTH=8 sharing one clock.
// Expected HI/LO/div_by_zero are queued at issue and checked by a monitor on each done pulse.
module tb_exec_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32_n, start32, mthi32, mtlo32, flush32, busy32, done32, dbz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;

  logic        rst8_n, start8, mthi8, mtlo8, flush8, busy8, done8, dbz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  exec_muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clock(clk), .reset_n(rst32_n), .start(start32), .op(op32), .operand_a(a32),
    .operand_b(b32), .mthi(mthi32), .mtlo(mtlo32), .wdata(wd32), .flush(flush32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  exec_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset_n(rst8_n), .start(start8), .op(op8), .operand_a(a8),
    .operand_b(b8), .mthi(mthi8), .mtlo(mtlo8), .wdata(wd8), .flush(flush8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done32 = 0;
  int   n_done8 = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  always @(negedge clk) begin
    if (rst32_n === 1'b1 && done32 === 1'b1) begin
      n_done32++;
      n_cmp++;
      if (q32.size() == 0) begin
        n_err++;
        $display("FAIL done32_unexpected: got done=1 want no pending result");
      end else begin
        e32 = q32.pop_front();
        if (hi32 !== e32.hi || lo32 !== e32.lo || dbz32 !== e32.dbz) begin
          n_err++;
          $display("FAIL result32: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                   hi32, lo32, dbz32, e32.hi, e32.lo, e32.dbz);
        end
      end
    end
    if (rst8_n === 1'b1 && done8 === 1'b1) begin
      n_done8++;
      n_cmp++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL done8_unexpected: got done=1 want no pending result");
      end else begin
        e8 = q8.pop_front();
        if ({24'h0, hi8} !== e8.hi || {24'h0, lo8} !== e8.lo || dbz8 !== e8.dbz) begin
          n_err++;
          $display("FAIL result8: got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                   hi8, lo8, dbz8, e8.hi[7:0], e8.lo[7:0], e8.dbz);
        end
      end
    end
  end

  function automatic exp_t model32(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t r;
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    r.dbz = 1'b0;
    r.hi  = '0;
    r.lo  = '0;
    p     = '0;
    case (op)
      2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'b01: p = {32'h0, a} * {32'h0, b};
      default: ;
    endcase
    if (!op[1]) begin
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 32'h0) begin
      r.hi  = a;
      r.lo  = 32'hFFFF_FFFF;
      r.dbz = 1'b1;
    end else if (op == 2'b10) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r.hi = 32'h0;
        r.lo = 32'h8000_0000;
      end else begin
        r.lo = sa / sb;
        r.hi = sa % sb;
      end
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic z);
    exp_t r;
    r.hi  = h;
    r.lo  = l;
    r.dbz = z;
    return r;
  endfunction

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst32_n = 1'b0; rst8_n = 1'b0;
    start32 = 0; mthi32 = 0; mtlo32 = 0; flush32 = 0; op32 = 0; a32 = 0; b32 = 0; wd32 = 0;
    start8 = 0; mthi8 = 0; mtlo8 = 0; flush8 = 0; op8 = 0; a8 = 0; b8 = 0; wd8 = 0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if ({hi32, lo32} !== 64'h0) begin
      n_err++; $display("FAIL reset_hilo32: got %h %h want 0 0", hi32, lo32);
    end
    if ({busy32, done32, dbz32} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags32: got %b want 000", {busy32, done32, dbz32});
    end
    if ({hi8, lo8, busy8, done8, dbz8} !== 19'h0) begin
      n_err++; $display("FAIL reset8: got %h %h %b want all zero", hi8, lo8,
                        {busy8, done8, dbz8});
    end
    rst32_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_latency32();
    int cyc = 0;
    int base = n_done32;
    bit early = 0;
    q32.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0));
    issue32(2'b00, 32'hFFFF_FFFD, 32'd7);
    while (busy32 === 1'b1 && cyc < 100) begin
      if (done32 !== 1'b0) early = 1;
      cyc++;
      @(negedge clk);
    end
    n_cmp += 4;
    if (cyc != 33) begin n_err++; $display("FAIL busy_len32: got %0d want 33", cyc); end
    if (early) begin n_err++; $display("FAIL done_early32: got done while busy want 0"); end
    if (done32 !== 1'b1) begin n_err++; $display("FAIL done32_at_end: got %b want 1", done32); end
    @(negedge clk);
    if (done32 !== 1'b0 || n_done32 != base + 1) begin
      n_err++; $display("FAIL done_pulse32: got done=%b count=%0d want 0 %0d",
                        done32, n_done32 - base, 1);
    end
  endtask

  task automatic test_multu_div32();
    q32.push_back(mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0));
    issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    q32.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0));
    q32.push_back(mk(32'h0, 32'h8000_0000, 1'b0));
    for (int i = 0; i < 100 && done32 !== 1'b1; i++) @(negedge clk);
    issue32(2'b10, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 100 && done32 !== 1'b1; i++) @(negedge clk);
    // Second divide issued in the done cycle of the first.
    issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    n_cmp++;
    if (busy32 !== 1'b1) begin n_err++; $display("FAIL back_to_back32: got busy=%b want 1", busy32); end
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (q32.size() != 0) begin n_err++; $display("FAIL drain_div32: got %0d pending want 0", q32.size()); end
  endtask

  task automatic test_div_zero32();
    q32.push_back(mk(32'h64, 32'hFFFF_FFFF, 1'b1));
    issue32(2'b11, 32'd100, 32'd0);
    for (int i = 0; i < 100 && q32.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (dbz32 !== 1'b1) begin n_err++; $display("FAIL dbz_sticky32: got %b want 1", dbz32); end
    q32.push_back(mk(32'h0, 32'd30, 1'b0));
    issue32(2'b00, 32'd5, 32'd6);
    if (dbz32 !== 1'b0) begin n_err++; $display("FAIL dbz_clear32: got %b want 0", dbz32); end
    for (int i = 0; i < 100 && q32.size() != 0; i++) @(negedge clk);
  endtask

  task automatic test_random32();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 8; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      q32.push_back(model32(op, a, b));
      issue32(op, a, b);
      for (int i = 0; i < 100 && busy32 === 1'b1; i++) @(negedge clk);
    end
    for (int i = 0; i < 100 && q32.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (q32.size() != 0) begin n_err++; $display("FAIL drain_rand32: got %0d pending want 0", q32.size()); end
  endtask

  task automatic test_busy_interference32();
    int base;
    mthi32 = 1'b1; wd32 = 32'h1234;
    @(negedge clk);
    mthi32 = 1'b0;
    n_cmp++;
    if (hi32 !== 32'h1234) begin n_err++; $display("FAIL mthi32: got %h want 00001234", hi32); end
    base = n_done32;
    q32.push_back(mk(32'h0, 32'd30, 1'b0));
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd5; b32 = 32'd6;
    mthi32 = 1'b1; mtlo32 = 1'b1; wd32 = 32'hFFFF_0000;
    @(negedge clk);
    start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0;
    repeat (3) @(negedge clk);
    start32 = 1'b1; op32 = 2'b11; a32 = 32'hFFFF_FFFF; b32 = 32'd1;
    mthi32 = 1'b1; mtlo32 = 1'b1; wd32 = 32'hABCD;
    repeat (5) @(negedge clk);
    start32 = 1'b0; mthi32 = 1'b0; mtlo32 = 1'b0;
    n_cmp += 2;
    if (hi32 !== 32'h1234) begin n_err++; $display("FAIL hi_hold_busy32: got %h want 00001234", hi32); end
    for (int i = 0; i < 100 && q32.size() != 0; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    if (n_done32 != base + 1 || busy32 !== 1'b0) begin
      n_err++; $display("FAIL interference32: got dones=%0d busy=%b want 1 0", n_done32 - base, busy32);
    end
  endtask

  task automatic test_flush32();
    int base;
    mthi32 = 1'b1; wd32 = 32'h1234;
    @(negedge clk);
    mthi32 = 1'b0;
    base = n_done32;
    issue32(2'b00, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    n_cmp += 3;
    if (busy32 !== 1'b0) begin n_err++; $display("FAIL flush_busy32: got %b want 0", busy32); end
    repeat (40) @(negedge clk);
    if (n_done32 != base || hi32 !== 32'h1234 || lo32 !== 32'd30 || dbz32 !== 1'b0) begin
      n_err++; $display("FAIL flush_state32: got dones=%0d hi=%h lo=%h dbz=%b want 0 1234 1e 0",
                        n_done32 - base, hi32, lo32, dbz32);
    end
    flush32 = 1'b1; mtlo32 = 1'b1; wd32 = 32'h55;
    @(negedge clk);
    flush32 = 1'b0; mtlo32 = 1'b0;
    if (lo32 !== 32'h55) begin n_err++; $display("FAIL flush_idle32: got lo=%h want 00000055", lo32); end
  endtask

  task automatic test_width8();
    int cyc = 0;
    q8.push_back(mk(32'hFF, 32'hEB, 1'b0));
    issue8(2'b00, 8'hFD, 8'd7);
    while (busy8 === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    n_cmp += 3;
    if (cyc != 9) begin n_err++; $display("FAIL busy_len8: got %0d want 9", cyc); end
    if (done8 !== 1'b1) begin n_err++; $display("FAIL done8_at_end: got %b want 1", done8); end
    @(negedge clk);
    q8.push_back(mk(32'hFF, 32'hFD, 1'b0));
    issue8(2'b10, 8'hF9, 8'd2);
    for (int i = 0; i < 40 && busy8 === 1'b1; i++) @(negedge clk);
    q8.push_back(mk(32'h00, 32'h80, 1'b0));
    issue8(2'b10, 8'h80, 8'hFF);
    for (int i = 0; i < 40 && busy8 === 1'b1; i++) @(negedge clk);
    q8.push_back(mk(32'h64, 32'hFF, 1'b1));
    issue8(2'b11, 8'h64, 8'h00);
    for (int i = 0; i < 100 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0 || dbz8 !== 1'b1) begin
      n_err++; $display("FAIL drain8: got pending=%0d dbz=%b want 0 1", q8.size(), dbz8);
    end
  endtask

  task automatic test_reset_mid8();
    int base;
    issue8(2'b00, 8'h12, 8'h34);
    repeat (4) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1;
    n_cmp += 2;
    if ({hi8, lo8, busy8, dbz8} !== 18'h0) begin
      n_err++; $display("FAIL reset_mid8: got hi=%h lo=%h busy=%b dbz=%b want all zero",
                        hi8, lo8, busy8, dbz8);
    end
    @(negedge clk);
    rst8_n = 1'b1;
    base = n_done8;
    repeat (20) @(negedge clk);
    if (n_done8 != base || busy8 !== 1'b0 || {hi8, lo8} !== 16'h0) begin
      n_err++; $display("FAIL reset_mid8_after: got dones=%0d busy=%b hi=%h lo=%h want 0 0 00 00",
                        n_done8 - base, busy8, hi8, lo8);
    end
  endtask

  initial begin
    test_reset();
    test_mult_latency32();
    test_multu_div32();
    test_div_zero32();
    test_random32();
    test_busy_interference32();
    test_flush32();
    test_width8();
    test_reset_mid8();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
